sum_accumulator: RTL and testbench



---
 rtl/accum_pkg.sv | 11 +
 rtl/sum_accumulator_if.sv | 27 ++
 rtl/accum_mean.sv | 34 +++
 rtl/sum_accumulator.sv | 103 ++++++++++
 tb/tb_sum_accumulator.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the sum_accumulator block: state encoding and default widths.
package accum_pkg;
  localparam int DEF_IN_W    = 11;
  localparam int DEF_N_LOG2  = 3;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;
endpackage

// File: rtl/sum_accumulator_if.sv
// Sample-in / frame-result-out handshake bundle for sum_accumulator.
interface sum_accumulator_if
  import accum_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int N_LOG2 = DEF_N_LOG2
);
  localparam int ACC_W = IN_W + N_LOG2;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [IN_W-1:0]   out_mean;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_mean
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_mean
  );
endinterface

// File: rtl/accum_mean.sv
// Combinational frame total -> mean. Define SUM_ACCUMULATOR_ROUND_EN for round-half-up
// with saturation; otherwise the mean truncates.
module accum_mean
  import accum_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int N_LOG2 = DEF_N_LOG2
) (
  input  logic [IN_W+N_LOG2-1:0] i_total,
  output logic [IN_W-1:0]        o_mean
);
  localparam int ACC_W = IN_W + N_LOG2;

`ifdef SUM_ACCUMULATOR_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (N_LOG2 - 1);

  // Bias by half an LSB of the result, then clamp if the bias carried past IN_W bits.
  function automatic logic [IN_W-1:0] mean_round(input logic [ACC_W-1:0] t);
    logic [ACC_W:0]        biased;
    logic [ACC_W-N_LOG2:0] q;
    biased = {1'b0, t} + HALF;
    q      = biased[ACC_W:N_LOG2];
    return q[IN_W] ? {IN_W{1'b1}} : q[IN_W-1:0];
  endfunction

  assign o_mean = mean_round(i_total);
`else
  function automatic logic [IN_W-1:0] mean_trunc(input logic [ACC_W-1:0] t);
    return t[ACC_W-1:N_LOG2];
  endfunction

  assign o_mean = mean_trunc(i_total);
`endif
endmodule

// File: rtl/sum_accumulator.sv
// Accumulates 2**N_LOG2 unsigned samples per frame and presents total and mean on an
// output handshake. Mean rounding is selected by SUM_ACCUMULATOR_ROUND_EN (see accum_mean).
module sum_accumulator
  import accum_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int N_LOG2 = DEF_N_LOG2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  sum_accumulator_if.slave       bus,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  localparam int ACC_W = IN_W + N_LOG2;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_W-1:0]       r_acc;
  logic [N_LOG2-1:0]      r_cnt;
  logic [ACC_W-1:0]       r_out_sum;
  logic [IN_W-1:0]        r_out_mean;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic [ACC_W-1:0]       w_total;
  logic [IN_W-1:0]        w_mean;
  logic                   w_in_fire;
  logic                   w_last;
  logic                   w_out_fire;

  // clr beats a coincident sample or result handshake.
  assign w_in_fire  = (r_state == ST_ACC) && bus.in_valid && !clr;
  assign w_last     = w_in_fire && (&r_cnt);
  assign w_out_fire = (r_state == ST_OUT) && bus.out_ready && !clr;
  assign w_total    = r_acc + ACC_W'(bus.in_data);

  accum_mean #(
    .IN_W   (IN_W),
    .N_LOG2 (N_LOG2)
  ) u_mean (
    .i_total (w_total),
    .o_mean  (w_mean)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:  if (w_last) w_state_nxt = ST_OUT;
      ST_OUT:  if (clr || w_out_fire) w_state_nxt = ST_ACC;
      default: w_state_nxt = ST_ACC;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_ACC:  bus.in_ready  = rst_n;
      ST_OUT:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_sum  <= '0;
      r_out_mean <= '0;
    end else if (clr && (r_state == ST_ACC)) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_last) begin
      r_out_sum  <= w_total;
      r_out_mean <= w_mean;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else if (w_in_fire) begin
      r_acc <= w_total;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_out_fire) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign bus.out_sum  = r_out_sum;
  assign bus.out_mean = r_out_mean;
  assign frame_cnt    = r_frame_cnt;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator (IN_W=11, N_LOG2=3); inputs driven and outputs
// sampled on the falling clock edge.
module tb_sum_accumulator;
  import accum_pkg::*;

  localparam int IN_W   = 11;
  localparam int N_LOG2 = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   clr;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  int                     checks;
  int                     failures;

  sum_accumulator_if #(.IN_W(IN_W), .N_LOG2(N_LOG2)) bus ();

  sum_accumulator #(
    .IN_W   (IN_W),
    .N_LOG2 (N_LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus.slave),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; presents n samples back to back, returns on a falling edge.
  task automatic feed(input int n, input logic [IN_W-1:0] val);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = val;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_mean3;
    logic [31:0] exp_mean_r;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef SUM_ACCUMULATOR_ROUND_EN
    exp_mean3  = 1;
    exp_mean_r = 2;
`else
    exp_mean3  = 0;
    exp_mean_r = 1;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_sum", 32'(bus.out_sum), 0);
    chk("rst_out_mean", 32'(bus.out_mean), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 1);

    // 1: 8 x 30
    bus.out_ready = 1'b1;
    feed(8, 11'd30);
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_in_ready", 32'(bus.in_ready), 0);
    chk("t1_out_sum", 32'(bus.out_sum), 240);
    chk("t1_out_mean", 32'(bus.out_mean), 30);
    @(negedge clk);
    chk("t1_valid_drop", 32'(bus.out_valid), 0);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);

    // 2: 8 x 2047, largest total
    feed(8, 11'd2047);
    chk("t2_out_sum", 32'(bus.out_sum), 16376);
    chk("t2_out_mean", 32'(bus.out_mean), 2047);
    @(negedge clk);
    chk("t2_frame_cnt", 32'(frame_cnt), 2);

    // 3: 7 x 0 then 4
    feed(7, 11'd0);
    feed(1, 11'd4);
    chk("t3_out_sum", 32'(bus.out_sum), 4);
    chk("t3_out_mean", 32'(bus.out_mean), exp_mean3);
    @(negedge clk);
    chk("t3_frame_cnt", 32'(frame_cnt), 3);

    // 4: back-pressure with ignored input pulses
    bus.out_ready = 1'b0;
    feed(8, 11'd100);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 11'd7;
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.out_valid), 1);
      chk("t4_hold_sum", 32'(bus.out_sum), 800);
      chk("t4_hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_drop", 32'(bus.out_valid), 0);
    chk("t4_in_ready", 32'(bus.in_ready), 1);
    chk("t4_frame_cnt", 32'(frame_cnt), 4);
    chk("t4_mean", 32'(bus.out_mean), 100);

    // 5: reset mid-frame
    feed(3, 11'd100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 0);
    rst_n = 1'b1;
    feed(8, 11'd10);
    chk("t5_out_sum", 32'(bus.out_sum), 80);
    chk("t5_out_mean", 32'(bus.out_mean), 10);
    @(negedge clk);
    chk("t5_frame_cnt", 32'(frame_cnt), 1);

    // 6: clr in ACC drops partial frame and the coincident sample
    feed(5, 11'd50);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 11'd50;
    @(negedge clk);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    feed(8, 11'd1);
    chk("t6_out_sum", 32'(bus.out_sum), 8);
    chk("t6_out_mean", 32'(bus.out_mean), 1);
    @(negedge clk);
    chk("t6_frame_cnt", 32'(frame_cnt), 2);

    // clr in OUT drops the pending result without counting it
    bus.out_ready = 1'b0;
    feed(8, 11'd5);
    chk("t7_out_sum", 32'(bus.out_sum), 40);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t7_valid_drop", 32'(bus.out_valid), 0);
    chk("t7_in_ready", 32'(bus.in_ready), 1);
    chk("t7_frame_cnt", 32'(frame_cnt), 2);

    // Total 12: rounding mode distinguishes 1 from 2
    bus.out_ready = 1'b1;
    feed(7, 11'd1);
    feed(1, 11'd5);
    chk("t8_out_sum", 32'(bus.out_sum), 12);
    chk("t8_out_mean", 32'(bus.out_mean), exp_mean_r);
    @(negedge clk);
    chk("t8_frame_cnt", 32'(frame_cnt), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
